// File: rtl/hd44780_ram_ctl.sv
// Single-clock character/command buffer for the HD44780 display path.
// Registered read, per-byte write mask, selectable read-during-write result,
// and a sequencer that fills every word with CLEAR_VALUE.
module hd44780_ram_ctl #(
    parameter int unsigned              ADDR_WIDTH  = 8,
    parameter int unsigned              DATA_WIDTH  = 16,
    parameter int                       RDW_NEW     = 0,
    parameter logic [DATA_WIDTH-1:0]    CLEAR_VALUE = '0,
    localparam int unsigned             LANES       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [LANES-1:0]      wr_mask,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  clear_start,
    output logic                  busy,
    output logic                  clear_done
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    logic [LANES-1:0]        lane_en;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_merged;
    logic                    rd_hit;

    assign wr_ready = ~busy;
    assign rd_word  = mem[rd_addr];
    // Lane enables are zero when nothing is written, so an address match alone is enough.
    assign rd_hit   = (RDW_NEW != 0) && (w_addr == rd_addr);

    // Select the single write port source: clear sequencer owns it while busy.
    always_comb begin
        lane_en = '0;
        w_addr  = wr_addr;
        w_data  = wr_data;
        if (busy) begin
            lane_en = '1;
            w_addr  = clr_addr;
            w_data  = CLEAR_VALUE;
        end else if (wr_en) begin
            lane_en = wr_mask;
        end
    end

    // Word as it will look after this edge's masked write, for same-address reads.
    always_comb begin
        rd_merged = rd_word;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                rd_merged[8*i +: 8] = w_data[8*i +: 8];
            end
        end
    end

    // Byte-lane masked memory write; contents are not reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    // Registered read with one-cycle valid strobe; data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_hit ? rd_merged : rd_word;
            end
        end
    end

    // Clear sequencer: walks every address once, then pulses clear_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            clr_addr   <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_start) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_ram_ctl.sv
// Bench for hd44780_ram_ctl: two instances (old-data and new-data read-during-write)
// share stimulus and are checked every cycle against a word-array reference model.
module tb_hd44780_ram_ctl;

    localparam int          D  = 256;
    localparam logic [15:0] CV = 16'h0020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en, rd_en, clear_start;
    logic [7:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_mask;

    logic [15:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1, busy0, busy1, done0, done1, wr_ready0, wr_ready1;

    // Reference model state
    logic [15:0] mmem [D];
    bit          m_busy, m_done, m_valid;
    int          m_ptr;
    logic [15:0] m_rd0, m_rd1;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    hd44780_ram_ctl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .RDW_NEW(0), .CLEAR_VALUE(CV)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_ready(wr_ready0), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .clear_start(clear_start),
        .busy(busy0), .clear_done(done0)
    );

    hd44780_ram_ctl #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .RDW_NEW(1), .CLEAR_VALUE(CV)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_ready(wr_ready1), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .clear_start(clear_start),
        .busy(busy1), .clear_done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] m);
        merge = old;
        if (m[0]) merge[7:0]  = d[7:0];
        if (m[1]) merge[15:8] = d[15:8];
    endfunction

    // Every cycle: both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rd_data_old", {16'h0, rd_data0}, {16'h0, m_rd0});
            chk("rd_data_new", {16'h0, rd_data1}, {16'h0, m_rd1});
            chk("rd_valid",    {30'h0, rd_valid1, rd_valid0}, {30'h0, m_valid, m_valid});
            chk("busy",        {30'h0, busy1, busy0}, {30'h0, m_busy, m_busy});
            chk("wr_ready",    {30'h0, wr_ready1, wr_ready0}, {30'h0, !m_busy, !m_busy});
            chk("clear_done",  {30'h0, done1, done0}, {30'h0, m_done, m_done});
        end
    end

    task automatic set_idle();
        wr_en = 1'b0; rd_en = 1'b0; clear_start = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0;
    endtask

    // One clock edge: model computes the outcome from pre-edge inputs, commits after the edge.
    task automatic step();
        bit          wrote;
        int          waddr;
        logic [15:0] wdata, nword, n_rd0, n_rd1;
        logic [1:0]  wm;
        bit          n_busy, n_done, n_valid;
        int          n_ptr;
        wrote = 1'b0; waddr = 0; wdata = '0; wm = '0;
        if (m_busy) begin
            wrote = 1'b1; waddr = m_ptr; wdata = CV; wm = 2'b11;
        end else if (wr_en) begin
            wrote = 1'b1; waddr = int'(wr_addr); wdata = wr_data; wm = wr_mask;
        end
        nword = merge(mmem[waddr], wdata, wm);
        n_rd0 = m_rd0; n_rd1 = m_rd1; n_valid = rd_en;
        if (rd_en) begin
            n_rd0 = mmem[rd_addr];
            n_rd1 = (wrote && waddr == int'(rd_addr)) ? nword : mmem[rd_addr];
        end
        n_ptr = m_ptr; n_done = 1'b0; n_busy = m_busy;
        if (m_busy) begin
            n_ptr = m_ptr + 1;
            if (m_ptr == D - 1) begin
                n_busy = 1'b0; n_done = 1'b1;
            end
        end else if (clear_start) begin
            n_busy = 1'b1; n_ptr = 0;
        end
        @(posedge clk);
        #1;
        if (wrote) mmem[waddr] = nword;
        m_rd0 = n_rd0; m_rd1 = n_rd1; m_valid = n_valid;
        m_busy = n_busy; m_done = n_done; m_ptr = n_ptr;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        step();
        set_idle();
    endtask

    task automatic rd(input logic [7:0] a);
        rd_en = 1'b1; rd_addr = a;
        step();
        set_idle();
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any edge.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_ptr = 0; m_rd0 = '0; m_rd1 = '0;
        #1;
        chk("rst_rd_data",  {16'h0, rd_data0}, 32'h0);
        chk("rst_rd_valid", {31'h0, rd_valid0}, 32'h0);
        chk("rst_busy",     {31'h0, busy0}, 32'h0);
        chk("rst_wr_ready", {31'h0, wr_ready0}, 32'h1);
        chk("rst_done",     {31'h0, done0}, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] hi);
        for (int a = 0; a < D; a++) wr(8'(a), {hi, 8'(a)}, 2'b11);
    endtask

    initial begin
        int cnt;
        set_idle();
        m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_ptr = 0; m_rd0 = '0; m_rd1 = '0;
        for (int a = 0; a < D; a++) mmem[a] = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("init_rd_valid", {31'h0, rd_valid0}, 32'h0);
        chk("init_wr_ready", {31'h0, wr_ready0}, 32'h1);
        cmp_en = 1'b1;

        // Preload and basic read
        preload(8'h00);
        rd(8'h6D);
        chk("read_6d",       {16'h0, rd_data0}, 32'h006D);
        chk("read_6d_valid", {31'h0, rd_valid0}, 32'h1);
        step();
        chk("valid_pulse",   {31'h0, rd_valid0}, 32'h0);
        chk("rd_hold",       {16'h0, rd_data0}, 32'h006D);
        apply_reset();

        // Masked writes
        wr(8'h6D, 16'hA5A5, 2'b11);
        wr(8'h6D, 16'h1234, 2'b01);
        rd(8'h6D);
        chk("mask_lo", {rd_data1, rd_data0}, 32'hA534_A534);
        wr(8'h6D, 16'hFFFF, 2'b00);
        rd(8'h6D);
        chk("mask_none", {rd_data1, rd_data0}, 32'hA534_A534);

        // Read during write, same address
        wr(8'h10, 16'h1111, 2'b11);
        wr_en = 1'b1; wr_addr = 8'h10; wr_data = 16'h2222; wr_mask = 2'b10;
        rd_en = 1'b1; rd_addr = 8'h10;
        step();
        set_idle();
        chk("rdw_old", {16'h0, rd_data0}, 32'h1111);
        chk("rdw_new", {16'h0, rd_data1}, 32'h2211);
        rd(8'h10);
        chk("rdw_after", {rd_data1, rd_data0}, 32'h2211_2211);

        // Back-to-back reads
        for (int i = 0; i < 6; i++) begin
            rd_en = 1'b1; rd_addr = 8'(8'h68 + i);
            step();
            chk("b2b_valid", {31'h0, rd_valid0}, 32'h1);
        end
        set_idle();

        // Full clear with dropped write and an in-flight read
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        chk("clr_busy_start",  {31'h0, busy0}, 32'h1);
        chk("clr_wr_ready",    {31'h0, wr_ready0}, 32'h0);
        for (int k = 1; k <= D; k++) begin
            if (k == 3) begin
                wr_en = 1'b1; wr_addr = 8'h05; wr_data = 16'hBEEF; wr_mask = 2'b11;
            end
            if (k == 10) begin
                rd_en = 1'b1; rd_addr = 8'hFF;
            end
            step();
            set_idle();
            if (k == 10) chk("clr_read_ff_old", {16'h0, rd_data0}, 32'h00FF);
            if (k < D) chk("clr_busy", {31'h0, busy0}, 32'h1);
        end
        chk("clr_end", {30'h0, busy0, done0}, 32'h1);
        step();
        chk("clr_done_low", {31'h0, done0}, 32'h0);
        for (int a = 0; a < D; a++) begin
            rd(8'(a));
            chk("clr_value", {16'h0, rd_data0}, {16'h0, CV});
        end

        // clear_start held through the whole clear: one clear only
        preload(8'hC3);
        clear_start = 1'b1;
        step();
        cnt = 1;
        for (int k = 1; k <= D; k++) begin
            step();
            if (busy0) cnt++;
        end
        clear_start = 1'b0;
        chk("retrig_cycles", cnt, 32'd256);
        step();
        chk("retrig_no_restart", {30'h0, busy0, done0}, 32'h0);
        rd(8'h80);
        chk("retrig_cleared", {16'h0, rd_data0}, {16'h0, CV});

        // Reset during clear
        preload(8'hC3);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        repeat (99) step();
        apply_reset();
        repeat (3) step();
        rd(8'h00); chk("abort_0",  {16'h0, rd_data0}, {16'h0, CV});
        rd(8'h62); chk("abort_98", {16'h0, rd_data0}, {16'h0, CV});
        rd(8'h63); chk("abort_99", {16'h0, rd_data0}, 32'hC363);
        rd(8'hFF); chk("abort_ff", {16'h0, rd_data0}, 32'hC3FF);

        // Randomized traffic, with occasional clears
        for (int i = 0; i < 3000; i++) begin
            bit narrow;
            narrow      = ($urandom_range(0, 1) == 1);
            wr_en       = ($urandom_range(0, 1) == 1);
            wr_addr     = narrow ? 8'($urandom_range(0, 7)) : 8'($urandom);
            wr_data     = 16'($urandom);
            wr_mask     = 2'($urandom);
            rd_en       = ($urandom_range(0, 9) < 6);
            rd_addr     = narrow ? 8'($urandom_range(0, 7)) : 8'($urandom);
            clear_start = ($urandom_range(0, 399) == 0);
            step();
        end
        set_idle();
        for (int i = 0; i < 300 && m_busy; i++) step();
        chk("final_idle", {31'h0, busy0}, 32'h0);
        for (int a = 0; a < D; a++) rd(8'(a));

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
